// File: rtl/sys_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sys_reset_sequencer
//  Description : Staged synchronous reset tree for the 50 MHz system domain.
//                Synchronises the PLL lock indication, qualifies it as stable,
//                then releases peripheral reset, memory reset and finally CPU
//                reset (after the memory controller reports init done, with an
//                optional timeout). Losing lock after the sequence has started
//                re-asserts every reset and reruns the sequence.
//
//  Ports       : clk           - system clock (PLL outclk_1, 50 MHz)
//                rst           - synchronous active-high reset
//                pll_locked    - PLL locked, asynchronous to clk
//                mem_init_done - memory controller init complete (level)
//                periph_reset  - active-high peripheral reset
//                mem_reset     - active-high memory controller reset
//                cpu_reset     - active-high CPU core reset
//                running       - high while cpu_reset is deasserted
//                fault         - sticky: memory init timeout occurred
//                lock_lost     - sticky: lock dropped after periph release
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 16,
    parameter int INIT_TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic mem_init_done,
    output logic periph_reset,
    output logic mem_reset,
    output logic cpu_reset,
    output logic running,
    output logic fault,
    output logic lock_lost
);

    // ------------------------------------------------------------------------
    // Counter geometry. A zero timeout disables the timeout; the counter is
    // then sized as if the limit were 1 so it never has zero width, and the
    // expiry compare is gated off by c_TO_EN.
    // ------------------------------------------------------------------------
    localparam int c_STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_STG_W  = $clog2(STAGGER_CYCLES + 1);
    localparam bit c_TO_EN  = (INIT_TIMEOUT_CYCLES != 0);
    localparam int c_TO_LIM = c_TO_EN ? INIT_TIMEOUT_CYCLES : 1;
    localparam int c_TO_W   = $clog2(c_TO_LIM + 1);

    localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STB_MAX  = c_STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [c_STB_W-1:0] c_STB_ONE  = c_STB_W'(1);
    localparam logic [c_STG_W-1:0] c_STG_LAST = c_STG_W'(STAGGER_CYCLES - 1);
    localparam logic [c_STG_W-1:0] c_STG_MAX  = c_STG_W'(STAGGER_CYCLES);
    localparam logic [c_STG_W-1:0] c_STG_ONE  = c_STG_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TO_LIM - 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(c_TO_LIM);
    localparam logic [c_TO_W-1:0]  c_TO_ONE   = c_TO_W'(1);

    // FSM encoding
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] c_ST_STAGGER   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_INIT = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_FAULT     = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [c_STB_W-1:0]     r_stable_cnt;
    logic [c_STG_W-1:0]     r_stagger_cnt;
    logic [c_TO_W-1:0]      r_timeout_cnt;
    logic                   w_lock_s;
    logic                   w_lock_drop;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Lock loss only matters once the sequence has left WAIT_LOCK; FAULT is
    // terminal and ignores lock entirely.
    assign w_lock_drop = !w_lock_s &&
                         ((r_state == c_ST_STAGGER) ||
                          (r_state == c_ST_WAIT_INIT) ||
                          (r_state == c_ST_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync        <= '0;
            r_state       <= c_ST_WAIT_LOCK;
            r_stable_cnt  <= '0;
            r_stagger_cnt <= '0;
            r_timeout_cnt <= '0;
            periph_reset  <= 1'b1;
            mem_reset     <= 1'b1;
            cpu_reset     <= 1'b1;
            running       <= 1'b0;
            fault         <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};

            if (w_lock_drop) begin
                r_state       <= c_ST_WAIT_LOCK;
                r_stable_cnt  <= '0;
                r_stagger_cnt <= '0;
                r_timeout_cnt <= '0;
                periph_reset  <= 1'b1;
                mem_reset     <= 1'b1;
                cpu_reset     <= 1'b1;
                running       <= 1'b0;
                lock_lost     <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_WAIT_LOCK: begin
                        // Leave on the cycle that completes the qualifying run,
                        // so periph_reset drops LOCK_STABLE_CYCLES after the
                        // first synchronised-high cycle.
                        if (!w_lock_s) begin
                            r_stable_cnt <= '0;
                        end else if (r_stable_cnt == c_STB_LAST) begin
                            r_stable_cnt <= '0;
                            r_state      <= c_ST_STAGGER;
                            periph_reset <= 1'b0;
                        end else if (r_stable_cnt != c_STB_MAX) begin
                            r_stable_cnt <= r_stable_cnt + c_STB_ONE;
                        end
                    end

                    c_ST_STAGGER: begin
                        if (r_stagger_cnt == c_STG_LAST) begin
                            r_stagger_cnt <= '0;
                            r_state       <= c_ST_WAIT_INIT;
                            mem_reset     <= 1'b0;
                        end else if (r_stagger_cnt != c_STG_MAX) begin
                            r_stagger_cnt <= r_stagger_cnt + c_STG_ONE;
                        end
                    end

                    c_ST_WAIT_INIT: begin
                        // Done is checked first so it wins over a coincident
                        // timeout expiry.
                        if (mem_init_done) begin
                            r_timeout_cnt <= '0;
                            r_state       <= c_ST_RUN;
                            cpu_reset     <= 1'b0;
                            running       <= 1'b1;
                        end else if (c_TO_EN && (r_timeout_cnt == c_TO_LAST)) begin
                            r_timeout_cnt <= '0;
                            r_state       <= c_ST_FAULT;
                            periph_reset  <= 1'b1;
                            mem_reset     <= 1'b1;
                            cpu_reset     <= 1'b1;
                            running       <= 1'b0;
                            fault         <= 1'b1;
                        end else if (r_timeout_cnt != c_TO_MAX) begin
                            r_timeout_cnt <= r_timeout_cnt + c_TO_ONE;
                        end
                    end

                    c_ST_RUN: begin
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end

                    c_ST_FAULT: begin
                        periph_reset <= 1'b1;
                        mem_reset    <= 1'b1;
                        cpu_reset    <= 1'b1;
                        running      <= 1'b0;
                        fault        <= 1'b1;
                    end

                    default: begin
                        // Unreachable encodings recover into a safe, fully
                        // reset sequence restart.
                        r_state      <= c_ST_WAIT_LOCK;
                        r_stable_cnt <= '0;
                        periph_reset <= 1'b1;
                        mem_reset    <= 1'b1;
                        cpu_reset    <= 1'b1;
                        running      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_reset_sequencer
//  Description : Self-checking bench for sys_reset_sequencer. A table of
//                {inputs, cycle count, expected outputs} segments describes a
//                continuous timeline; each cycle the inputs are driven, the
//                expected output word is queued, and at the falling edge the
//                DUT outputs are popped against it.
//                Expected word bit order:
//                {periph_reset, mem_reset, cpu_reset, running, fault, lock_lost}
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_reset_sequencer;

    localparam int c_SYNC    = 2;
    localparam int c_STABLE  = 8;
    localparam int c_STAGGER = 4;
    localparam int c_TIMEOUT = 32;
    localparam int c_WATCHDOG_CYCLES = 2000;

    // Output words
    localparam logic [5:0] c_RST   = 6'b111000; // all resets held
    localparam logic [5:0] c_PER   = 6'b011000; // periph released
    localparam logic [5:0] c_MEM   = 6'b001000; // periph+mem released
    localparam logic [5:0] c_RUN   = 6'b000100; // running
    localparam logic [5:0] c_RST_L = 6'b111001;
    localparam logic [5:0] c_PER_L = 6'b011001;
    localparam logic [5:0] c_MEM_L = 6'b001001;
    localparam logic [5:0] c_RUN_L = 6'b000101;
    localparam logic [5:0] c_FLT   = 6'b111010;

    logic clk;
    logic rst;
    logic pll_locked;
    logic mem_init_done;
    logic periph_reset;
    logic mem_reset;
    logic cpu_reset;
    logic running;
    logic fault;
    logic lock_lost;

    sys_reset_sequencer #(
        .SYNC_STAGES        (c_SYNC),
        .LOCK_STABLE_CYCLES (c_STABLE),
        .STAGGER_CYCLES     (c_STAGGER),
        .INIT_TIMEOUT_CYCLES(c_TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .mem_init_done(mem_init_done),
        .periph_reset (periph_reset),
        .mem_reset    (mem_reset),
        .cpu_reset    (cpu_reset),
        .running      (running),
        .fault        (fault),
        .lock_lost    (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pll;
        logic       done;
        int         n;
        logic [5:0] exp;
    } seg_t;

    seg_t       segs[$];
    logic [5:0] exp_q[$];
    int         checks;
    int         errors;
    int         cycle;
    logic       done_flag;

    function automatic void add(input logic r, input logic p, input logic d,
                                input int n, input logic [5:0] e);
        seg_t s;
        s.rst  = r;
        s.pll  = p;
        s.done = d;
        s.n    = n;
        s.exp  = e;
        segs.push_back(s);
    endfunction

    initial begin
        done_flag = 1'b0;
        repeat (c_WATCHDOG_CYCLES) @(posedge clk);
        if (!done_flag) begin
            errors++;
            $display("FAIL watchdog expired after %0d cycles waiting for the timeline to finish",
                     c_WATCHDOG_CYCLES);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        logic [5:0] got;
        logic [5:0] want;
        checks = 0;
        errors = 0;
        cycle  = 0;

        // ---- Nominal: lock at 10, lock_s at 12, done at 30 -----------------
        add(0, 0, 0, 10, c_RST);       // 0..9   reset-state outputs
        add(0, 1, 0, 10, c_RST);       // 10..19 sync + stable qualification
        add(0, 1, 0,  4, c_PER);       // 20..23 periph released
        add(0, 1, 0,  6, c_MEM);       // 24..29 mem released
        add(0, 1, 1,  1, c_MEM);       // 30     done sampled
        add(0, 1, 1, 10, c_RUN);       // 31..40 running
        // ---- Lock loss in RUN: drop at 41, resets at 44 --------------------
        add(0, 0, 1,  3, c_RUN);       // 41..43
        add(0, 0, 1,  6, c_RST_L);     // 44..49
        // ---- Re-lock with done already high (early done) -------------------
        add(0, 1, 1, 10, c_RST_L);     // 50..59
        add(0, 1, 1,  4, c_PER_L);     // 60..63
        add(0, 1, 1,  1, c_MEM_L);     // 64     first WAIT_INIT cycle
        add(0, 1, 1,  5, c_RUN_L);     // 65..69
        // ---- Second lock loss, re-lock, rst during WAIT_INIT ---------------
        add(0, 0, 0,  3, c_RUN_L);     // 70..72
        add(0, 0, 0,  7, c_RST_L);     // 73..79
        add(0, 1, 0, 10, c_RST_L);     // 80..89
        add(0, 1, 0,  4, c_PER_L);     // 90..93
        add(0, 1, 0,  2, c_MEM_L);     // 94..95
        add(1, 1, 0,  1, c_MEM_L);     // 96     rst pulse
        // ---- Restart with full 2+8+4 latency, then init timeout -----------
        add(0, 1, 0, 10, c_RST);       // 97..106
        add(0, 1, 0,  4, c_PER);       // 107..110
        add(0, 1, 0, 32, c_MEM);       // 111..142 timeout window
        for (int i = 0; i < 10; i++)   // 143..242 FAULT holds, lock toggles
            add(0, logic'(i[0]), logic'(i[1]), 10, c_FLT);
        add(1, 0, 0,  1, c_FLT);       // rst clears fault
        // ---- Lock glitch: 5 high, 1 low, then high -------------------------
        add(0, 1, 0,  5, c_RST);
        add(0, 0, 0,  1, c_RST);
        add(0, 1, 0, 10, c_RST);
        add(0, 1, 0,  4, c_PER);
        add(0, 1, 0,  3, c_MEM);
        add(0, 1, 1,  1, c_MEM);
        add(0, 1, 1,  3, c_RUN);
        // ---- Done on the last timeout cycle wins ---------------------------
        add(1, 1, 0,  1, c_RUN);
        add(0, 1, 0, 10, c_RST);
        add(0, 1, 0,  4, c_PER);
        add(0, 1, 0, 31, c_MEM);
        add(0, 1, 1,  1, c_MEM);
        add(0, 1, 1,  4, c_RUN);

        rst           = 1'b1;
        pll_locked    = 1'b0;
        mem_init_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        got = {periph_reset, mem_reset, cpu_reset, running, fault, lock_lost};
        checks++;
        if (got !== c_RST) begin
            errors++;
            $display("FAIL reset state outputs got %b expected %b (periph,mem,cpu,running,fault,lock_lost)",
                     got, c_RST);
        end

        for (int s = 0; s < segs.size(); s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                rst           = segs[s].rst;
                pll_locked    = segs[s].pll;
                mem_init_done = segs[s].done;
                exp_q.push_back(segs[s].exp);
                @(negedge clk);
                got  = {periph_reset, mem_reset, cpu_reset, running, fault, lock_lost};
                want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL seg%0d cycle %0d outputs got %b expected %b (periph,mem,cpu,running,fault,lock_lost)",
                             s, cycle, got, want);
                end
                @(posedge clk);
                #1;
                cycle++;
            end
        end

        done_flag = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
